// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC core and its host-side controller:
// operand format, mode encoding and controller state encoding.
package cordic_pkg;

  localparam int W    = 16;
  localparam int FRAC = 8;

  localparam logic MODE_ROT = 1'b1;
  localparam logic MODE_VEC = 1'b0;

  // Sign-magnitude negative zero: sign set, magnitude clear.
  localparam logic [W-1:0] NEG_ZERO = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/cordic_host_ctrl.sv
// Host-side initiator for the iterative cordic core: accepts one job, restarts
// the core, waits its fixed latency, captures and returns the tagged results.
module cordic_host_ctrl #(
  parameter int W       = cordic_pkg::W,
  parameter int LATENCY = 16,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic [W-1:0]     cmd_x,
  input  logic [W-1:0]     cmd_y,
  input  logic [W-1:0]     cmd_z,
  output logic             cor_mode,
  output logic [W-1:0]     cor_x,
  output logic [W-1:0]     cor_y,
  output logic [W-1:0]     cor_z,
  output logic             cor_reset,
  input  logic [W-1:0]     cor_res1,
  input  logic [W-1:0]     cor_res2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_res1,
  output logic [W-1:0]     rsp_res2,
  output logic             rsp_mode,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);
  import cordic_pkg::*;

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [W-1:0] L_NEG_ZERO = {1'b1, {(W-1){1'b0}}};

  function automatic logic [W-1:0] normalise(input logic [W-1:0] v);
    return (v == L_NEG_ZERO) ? '0 : v;
  endfunction

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [TAG_W-1:0]   r_tag_cnt;
  logic               r_cor_mode;
  logic [W-1:0]       r_cor_x;
  logic [W-1:0]       r_cor_y;
  logic [W-1:0]       r_cor_z;
  logic               r_cor_reset;
  logic [W-1:0]       r_rsp_res1;
  logic [W-1:0]       r_rsp_res2;
  logic               r_rsp_mode;
  logic [TAG_W-1:0]   r_rsp_tag;
  logic               w_accept;
  logic               w_cnt_done;

  assign w_accept   = (r_state == S_IDLE) && cmd_valid;
  assign w_cnt_done = (r_cnt == CNT_W'(LATENCY - 1));

  // NOTE: reset is synchronous here, so it lives inside the clocked block and
  // every register, state included, is updated with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: next_state gets a default first so no path through the case infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (cmd_valid)  w_next_state = S_LOAD;
      S_LOAD:                 w_next_state = S_RUN;
      S_RUN:  if (w_cnt_done) w_next_state = S_DONE;
      S_DONE: if (rsp_ready)  w_next_state = S_IDLE;
      default:                w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_tag_cnt   <= '0;
      r_cor_mode  <= 1'b0;
      r_cor_x     <= '0;
      r_cor_y     <= '0;
      r_cor_z     <= '0;
      r_cor_reset <= 1'b0;
      r_rsp_res1  <= '0;
      r_rsp_res2  <= '0;
      r_rsp_mode  <= 1'b0;
      r_rsp_tag   <= '0;
    end else begin
      // Registered so the core sees a glitch-free restart pulse during LOAD.
      r_cor_reset <= (w_next_state != S_LOAD);

      if (w_accept) begin
        r_cor_mode <= cmd_mode;
        r_cor_x    <= cmd_x;
        r_cor_y    <= cmd_y;
        r_cor_z    <= cmd_z;
        r_rsp_tag  <= r_tag_cnt;
        r_tag_cnt  <= r_tag_cnt + 1'b1;
      end

      if (r_state == S_LOAD)     r_cnt <= '0;
      else if (r_state == S_RUN) r_cnt <= r_cnt + 1'b1;

      if ((r_state == S_RUN) && w_cnt_done) begin
        r_rsp_res1 <= normalise(cor_res1);
        r_rsp_res2 <= normalise(cor_res2);
        r_rsp_mode <= r_cor_mode;
      end
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = (r_state == S_DONE);
  assign cor_mode  = r_cor_mode;
  assign cor_x     = r_cor_x;
  assign cor_y     = r_cor_y;
  assign cor_z     = r_cor_z;
  assign cor_reset = r_cor_reset;
  assign rsp_res1  = r_rsp_res1;
  assign rsp_res2  = r_rsp_res2;
  assign rsp_mode  = r_rsp_mode;
  assign rsp_tag   = r_rsp_tag;

endmodule

// File: tb/tb_cordic_host_ctrl.sv
// Directed bench for cordic_host_ctrl with a stub core that presents the
// programmed results only on the cycle the capture is due.
module tb_cordic_host_ctrl;

  localparam int W       = 16;
  localparam int LATENCY = 16;
  localparam int TAG_W   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_mode;
  logic [W-1:0]     cmd_x, cmd_y, cmd_z;
  logic             cor_mode;
  logic [W-1:0]     cor_x, cor_y, cor_z;
  logic             cor_reset;
  logic [W-1:0]     cor_res1, cor_res2;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_res1, rsp_res2;
  logic             rsp_mode;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] stub_r1 = '0;
  logic [W-1:0] stub_r2 = '0;
  logic [7:0]   stub_cnt = '0;

  always #5 clk = ~clk;

  cordic_host_ctrl #(.W(W), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_z(cmd_z),
    .cor_mode(cor_mode), .cor_x(cor_x), .cor_y(cor_y), .cor_z(cor_z),
    .cor_reset(cor_reset), .cor_res1(cor_res1), .cor_res2(cor_res2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res1(rsp_res1), .rsp_res2(rsp_res2), .rsp_mode(rsp_mode),
    .rsp_tag(rsp_tag), .busy(busy)
  );

  // Stub core: counts cycles since restart release, results valid only when
  // exactly LATENCY cycles have elapsed, otherwise a junk pattern.
  always @(posedge clk) begin
    if (!cor_reset)            stub_cnt <= '0;
    else if (stub_cnt != 8'hFF) stub_cnt <= stub_cnt + 8'd1;
  end
  assign cor_res1 = (stub_cnt == 8'(LATENCY - 1)) ? stub_r1 : 16'hDEAD;
  assign cor_res2 = (stub_cnt == 8'(LATENCY - 1)) ? stub_r2 : 16'hBEEF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  // Present a command for one edge, then wait (bounded) for the response,
  // counting how many samples saw the core held in reset.
  task automatic run_job(input string tag, input logic m, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] z);
    int n;
    int lows;
    cmd_valid = 1'b1; cmd_mode = m; cmd_x = x; cmd_y = y; cmd_z = z;
    tick();
    cmd_valid = 1'b0; cmd_x = 16'h7777; cmd_y = 16'h6666; cmd_z = 16'h5555; cmd_mode = ~m;
    check({tag, ".cor_ops"}, {15'd0, cor_mode, cor_x}, {15'd0, m, x});
    check({tag, ".cor_yz"}, {cor_y, cor_z}, {y, z});
    check({tag, ".busy"}, {30'd0, busy, cmd_ready}, 32'b10);
    n = 0;
    lows = cor_reset ? 0 : 1;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
      if (!cor_reset) lows++;
    end
    check({tag, ".latency"}, 32'(n), 32'(LATENCY + 1));
    check({tag, ".core_reset_cycles"}, 32'(lows), 32'd1);
  endtask

  initial begin
    int hi_seen;
    int accepts, rsps, last_acc;

    reset = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_z = '0; rsp_ready = 1'b0;

    // Reset
    repeat (3) tick();
    check("rst.ctrl", {28'd0, cmd_ready, rsp_valid, busy, cor_reset}, 32'b1000);
    check("rst.cor", {15'd0, cor_mode, cor_x}, 32'd0);
    check("rst.cor_yz", {cor_y, cor_z}, 32'd0);
    check("rst.rsp", {rsp_res1, rsp_res2}, 32'd0);
    check("rst.rsp_mt", {27'd0, rsp_mode, rsp_tag}, 32'd0);
    reset = 1'b1;
    tick();
    check("rst.release", {31'd0, cor_reset}, 32'd1);

    // Single rotation job
    stub_r1 = 16'h1234; stub_r2 = 16'h8100;
    run_job("rot", 1'b1, 16'h9994, 16'h9EC1, 16'h01DF);
    check("rot.res", {rsp_res1, rsp_res2}, 32'h1234_8100);
    check("rot.mt", {27'd0, rsp_mode, rsp_tag}, {27'd0, 1'b1, 4'd0});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rot.idle", {29'd0, rsp_valid, cmd_ready, busy}, 32'b010);
    check("rot.ops_held", {cor_x, cor_z}, 32'h9994_01DF);

    // Vectoring job with backpressure
    stub_r1 = 16'h0A00; stub_r2 = 16'h00C0;
    run_job("vec", 1'b0, 16'h9994, 16'h9EC1, 16'h01DF);
    for (int i = 0; i < 10; i++) begin
      check("vec.hold_res", {rsp_res1, rsp_res2}, 32'h0A00_00C0);
      check("vec.hold_ctl", {26'd0, rsp_valid, cmd_ready, rsp_mode, rsp_tag}, {26'd0, 1'b1, 1'b0, 1'b0, 4'd1});
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("vec.idle", {29'd0, rsp_valid, cmd_ready, busy}, 32'b010);

    // Negative-zero normalisation
    stub_r1 = 16'h8000; stub_r2 = 16'h8001;
    run_job("nz", 1'b1, 16'h0100, 16'h0000, 16'h0080);
    check("nz.res", {rsp_res1, rsp_res2}, 32'h0000_8001);
    check("nz.tag", {28'd0, rsp_tag}, 32'd2);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset during RUN abandons the job and clears the tag counter
    cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_x = 16'h0200;
    tick();
    cmd_valid = 1'b0;
    repeat (6) tick();
    reset = 1'b0;
    tick();
    check("mid.rst", {29'd0, busy, rsp_valid, cor_reset}, 32'd0);
    reset = 1'b1;
    hi_seen = 0;
    for (int i = 0; i < LATENCY + 5; i++) begin
      tick();
      if (rsp_valid) hi_seen++;
    end
    check("mid.no_rsp", 32'(hi_seen), 32'd0);
    stub_r1 = 16'h0055; stub_r2 = 16'h00AA;
    run_job("mid.next", 1'b0, 16'h0011, 16'h0022, 16'h0033);
    check("mid.next_tag", {28'd0, rsp_tag}, 32'd0);
    check("mid.next_res", {rsp_res1, rsp_res2}, 32'h0055_00AA);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Back-to-back jobs: tag wrap and minimum job period
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    stub_r1 = 16'h0100; stub_r2 = 16'h0200;
    cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_x = 16'h0300; cmd_y = 16'h0400; cmd_z = 16'h0010;
    rsp_ready = 1'b1;
    accepts = 0; rsps = 0; last_acc = -1;
    for (int c = 0; c < 2000 && rsps < 17; c++) begin
      check("wrap.ready_vs_busy", {31'd0, cmd_ready}, {31'd0, ~busy});
      if (cmd_valid && cmd_ready) begin
        if (accepts > 0) check("wrap.period", 32'(c - last_acc), 32'(LATENCY + 3));
        last_acc = c;
        accepts++;
      end
      if (rsp_valid && rsp_ready) begin
        check("wrap.tag", {28'd0, rsp_tag}, 32'(rsps % 16));
        check("wrap.res", {rsp_res1, rsp_res2}, 32'h0100_0200);
        rsps++;
      end
      tick();
      if (accepts == 17) cmd_valid = 1'b0;
    end
    check("wrap.responses", 32'(rsps), 32'd17);
    check("wrap.accepts", 32'(accepts), 32'd17);
    rsp_ready = 1'b0;
    tick();
    check("wrap.idle", {30'd0, busy, rsp_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
